// File: rtl/adv_cfg_pkg.sv
// adv_cfg_pkg: shared types and ADV7513 register map constants for the config sequencer (rev 1.0).
`default_nettype none

package adv_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HPD_WAIT = 4'd1,
    S_LOAD     = 4'd2,
    S_ISSUE    = 4'd3,
    S_WAIT_RSP = 4'd4,
    S_DELAY    = 4'd5,
    S_NEXT     = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } cfg_state_t;

  typedef struct packed {
    logic       is_delay;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam logic [7:0] ADV_REG_POWER      = 8'h41;
  localparam logic [7:0] ADV_REG_VID_IN     = 8'h15;
  localparam logic [7:0] ADV_REG_VID_STYLE  = 8'h16;
  localparam logic [7:0] ADV_REG_VID_ASPECT = 8'h17;
  localparam logic [7:0] ADV_REG_CSC_CTRL   = 8'h18;
  localparam logic [7:0] ADV_REG_HDMI_MODE  = 8'hAF;
  localparam logic [7:0] ADV_REG_AVI_0      = 8'h55;
  localparam logic [7:0] ADV_REG_AVI_1      = 8'h56;
  localparam logic [7:0] ADV_REG_HPD_CFG    = 8'hD6;

  function automatic cfg_entry_t wr(input logic [7:0] reg_addr, input logic [7:0] data);
    return '{is_delay: 1'b0, reg_addr: reg_addr, data: data};
  endfunction

  function automatic cfg_entry_t dly(input logic [7:0] units);
    return '{is_delay: 1'b1, reg_addr: 8'h00, data: units};
  endfunction

endpackage

`default_nettype wire

// File: rtl/adv_init_rom.sv
// adv_init_rom: ADV7513 power-up table, combinational idx -> entry lookup (rev 1.0).
`default_nettype none

module adv_init_rom
  import adv_cfg_pkg::*;
(
  input  logic [7:0] idx,
  output cfg_entry_t entry
);

  always_comb begin
    entry = '0;
    case (idx)
      8'd0:  entry = wr(ADV_REG_POWER, 8'h10);
      8'd1:  entry = wr(8'h98, 8'h03);
      8'd2:  entry = wr(8'h9A, 8'hE0);
      8'd3:  entry = dly(8'd2);
      8'd4:  entry = wr(8'h9C, 8'h30);
      8'd5:  entry = wr(8'h9D, 8'h61);
      8'd6:  entry = wr(8'hA2, 8'hA4);
      8'd7:  entry = wr(8'hA3, 8'hA4);
      8'd8:  entry = wr(8'hE0, 8'hD0);
      8'd9:  entry = wr(8'hF9, 8'h00);
      8'd10: entry = wr(ADV_REG_VID_IN, 8'h00);
      8'd11: entry = wr(ADV_REG_VID_STYLE, 8'h30);
      8'd12: entry = wr(ADV_REG_VID_ASPECT, 8'h02);
      8'd13: entry = wr(ADV_REG_CSC_CTRL, 8'h46);
      8'd14: entry = wr(ADV_REG_HDMI_MODE, 8'h06);
      8'd15: entry = wr(8'h40, 8'h80);
      8'd16: entry = wr(8'h4C, 8'h04);
      8'd17: entry = wr(ADV_REG_AVI_0, 8'h10);
      8'd18: entry = wr(ADV_REG_AVI_1, 8'h08);
      8'd19: entry = wr(8'h96, 8'h20);
      8'd20: entry = wr(ADV_REG_HPD_CFG, 8'hC0);
      8'd21: entry = wr(8'hBA, 8'h60);
      8'd22: entry = wr(8'h0A, 8'h01);
      8'd23: entry = wr(8'h0B, 8'h0E);
      8'd24: entry = wr(8'h0C, 8'hBC);
      8'd25: entry = wr(8'h01, 8'h00);
      8'd26: entry = wr(8'h02, 8'h18);
      8'd27: entry = wr(8'h03, 8'h00);
      8'd28: entry = wr(8'hD0, 8'h3C);
      8'd29: entry = wr(8'h48, 8'h08);
      8'd30: entry = dly(8'd1);
      8'd31: entry = wr(ADV_REG_POWER, 8'h10);
      default: entry = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/adv_config_sequencer.sv
// adv_config_sequencer: walks the ADV7513 init table and issues I2C register writes with NACK retry (rev 1.0).
// Optional hot-plug gating is enabled by defining ADV_CFG_HPD_EN.
`default_nettype none

module adv_config_sequencer
  import adv_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         NUM_ENTRIES = 32,
  parameter int         MAX_RETRY   = 3,
  parameter int         DELAY_TICKS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hpd,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [6:0] req_dev,
  output logic [7:0] req_reg,
  output logic [7:0] req_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_index
);

  localparam int         CNT_W       = $clog2(255 * DELAY_TICKS + 1);
  localparam logic [7:0] LAST_IDX    = 8'(NUM_ENTRIES - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  cfg_state_t       state, next_state;
  cfg_entry_t       rom_entry;
  logic [7:0]       idx;
  logic [3:0]       retry;
  logic [CNT_W-1:0] dly_cnt;
  logic [CNT_W-1:0] dly_load;
  logic             start_q;
  logic             start_rise;
  logic             run_start;
  logic             hpd_gate;

  adv_init_rom u_rom (
    .idx   (idx),
    .entry (rom_entry)
  );

  assign start_rise = start & ~start_q;
  assign dly_load   = CNT_W'(rom_entry.data) * CNT_W'(DELAY_TICKS);

`ifdef ADV_CFG_HPD_EN
  localparam cfg_state_t RUN_ENTRY = S_HPD_WAIT;
  logic hpd_q;
  logic hpd_rise;
  logic hpd_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hpd_q <= 1'b0;
    else       hpd_q <= hpd;
  end

  assign hpd_rise = hpd & ~hpd_q;
  assign hpd_fall = ~hpd & hpd_q;
  assign hpd_gate = hpd;
`else
  localparam cfg_state_t RUN_ENTRY = S_LOAD;
  logic hpd_unused;
  assign hpd_unused = hpd;
  assign hpd_gate   = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    run_start  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_rise) begin
          run_start  = 1'b1;
          next_state = RUN_ENTRY;
        end
`ifdef ADV_CFG_HPD_EN
        if (state == S_DONE && hpd_rise) begin
          run_start  = 1'b1;
          next_state = S_HPD_WAIT;
        end
`endif
      end
      S_HPD_WAIT: if (hpd_gate) next_state = S_LOAD;
      S_LOAD:     next_state = rom_entry.is_delay ? S_DELAY : S_ISSUE;
      S_ISSUE:    if (req_ready) next_state = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack)                 next_state = S_NEXT;
          else if (retry == RETRY_LIMIT) next_state = S_ERROR;
          else                           next_state = S_ISSUE;
        end
      end
      // A zero-length delay still spends one cycle here before moving on.
      S_DELAY:    if (dly_cnt == '0) next_state = S_NEXT;
      S_NEXT:     next_state = (idx == LAST_IDX) ? S_DONE : S_LOAD;
      default:    next_state = S_IDLE;
    endcase
`ifdef ADV_CFG_HPD_EN
    if (hpd_fall && state != S_IDLE) begin
      next_state = S_IDLE;
      run_start  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      retry     <= '0;
      dly_cnt   <= '0;
      req_reg   <= '0;
      req_data  <= '0;
      err_index <= '0;
      start_q   <= 1'b0;
    end else begin
      start_q <= start;
      if (run_start) begin
        idx       <= '0;
        retry     <= '0;
        err_index <= '0;
      end
      case (state)
        S_LOAD: begin
          if (rom_entry.is_delay) begin
            dly_cnt <= dly_load;
          end else begin
            req_reg  <= rom_entry.reg_addr;
            req_data <= rom_entry.data;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid && rsp_nack && next_state != S_IDLE) begin
            if (retry == RETRY_LIMIT) err_index <= idx;
            else                      retry     <= retry + 4'd1;
          end
        end
        S_DELAY: if (dly_cnt != '0) dly_cnt <= dly_cnt - CNT_W'(1);
        S_NEXT: begin
          retry <= '0;
          if (idx != LAST_IDX) idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_valid = (state == S_ISSUE);
  assign req_dev   = DEV_ADDR;
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign busy      = !(state == S_IDLE || state == S_DONE || state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_adv_config_sequencer.sv
// tb_adv_config_sequencer: randomized scoreboard bench for adv_config_sequencer (default build, HPD unused).
`timescale 1ns/1ps
`default_nettype none

module tb_adv_config_sequencer;

  localparam int N    = 8;
  localparam int MAXR = 3;
  localparam int DT   = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       hpd = 1'b0;
  logic       req_ready = 1'b0;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
  logic       req_valid, busy, done, error;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_data, err_index;

  adv_config_sequencer #(
    .DEV_ADDR    (7'h39),
    .NUM_ENTRIES (N),
    .MAX_RETRY   (MAXR),
    .DELAY_TICKS (DT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .hpd       (hpd),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dev   (req_dev),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] rg;
    logic [7:0] dt;
    int         min_gap;
    bit         first;
  } exp_t;

  exp_t        exp_q[$];
  bit          nack_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle = 0;
  int          rsp_timer = 0;
  bit          ready_low = 1'b0;
  bit          exp_done, exp_err;
  int          exp_idx;
  logic [16:0] tbl [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clock) cycle <= cycle + 1;

  // Engine model: random ready, response a few cycles after each accepted request.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      req_ready = ready_low ? 1'b0 : ($urandom % 4 != 0);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (rsp_timer > 0) begin
        rsp_timer--;
        if (rsp_timer == 0) begin
          rsp_valid = 1'b1;
          rsp_nack  = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        end
      end
    end
  end

  // Monitor: compares every accepted request against the scoreboard.
  initial begin
    bit         pv = 1'b0;
    bit         phs = 1'b0;
    logic [7:0] pr = '0, pd = '0;
    int         last_rsp = 0;
    int         gap;
    exp_t       e;
    forever begin
      @(negedge clock);
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (rsp_valid) last_rsp = cycle;
      if (pv && !phs) begin
        check("req_hold_valid", 32'(req_valid), 32'd1);
        check("req_hold_fields", {16'd0, req_reg, req_data}, {16'd0, pr, pd});
      end
      if (req_valid && !pv && exp_q.size() > 0 && !exp_q[0].first) begin
        gap = cycle - last_rsp;
        check("req_gap_min", 32'(gap >= exp_q[0].min_gap), 32'd1);
        check("req_gap_max", 32'(gap <= exp_q[0].min_gap + 8), 32'd1);
      end
      phs = req_valid && req_ready;
      if (phs) begin
        rsp_timer = $urandom_range(1, 4);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: got reg %0h data %0h, expected no request", req_reg, req_data);
        end else begin
          e = exp_q.pop_front();
          check("req_dev", 32'(req_dev), 32'h39);
          check("req_reg_data", {16'd0, req_reg, req_data}, {16'd0, e.rg, e.dt});
        end
      end
      pv = req_valid;
      pr = req_reg;
      pd = req_data;
    end
  end

  // Reference model: expand the table and planned NACK counts into the request stream.
  task automatic plan_run(input int nk[N]);
    int gap = 1;
    bit first = 1'b1;
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < N; i++) begin
      if (tbl[i][16]) begin
        gap = int'(tbl[i][7:0]) * DT;
        if (gap < 1) gap = 1;
        continue;
      end
      for (int a = 0; a <= MAXR; a++) begin
        exp_q.push_back('{tbl[i][15:8], tbl[i][7:0], gap, first});
        first = 1'b0;
        gap   = 1;
        nack_q.push_back(a < nk[i]);
        if (a >= nk[i]) break;
      end
      if (nk[i] > MAXR) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_idx  = i;
        return;
      end
    end
  endtask

  task automatic do_run(input int nk[N], input bit hold_start, input int ready_low_cycles);
    int t = 0;
    plan_run(nk);
    ready_low = (ready_low_cycles > 0);
    @(posedge clock); #1;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    if (!hold_start) start = 1'b0;
    if (ready_low_cycles > 0) begin
      repeat (ready_low_cycles) @(posedge clock);
      ready_low = 1'b0;
    end
    while (!(done || error) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: got no done/error after %0d cycles, expected completion", t);
    end
    repeat (20) @(negedge clock);
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    if (exp_err) check("err_index", 32'(err_index), 32'(exp_idx));
    check("busy_end", 32'(busy), 32'd0);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("nack_queue_empty", 32'(nack_q.size()), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int nk[N];
    int t;
    int r;
    tbl = '{ {1'b0, 8'h41, 8'h10}, {1'b0, 8'h98, 8'h03}, {1'b0, 8'h9A, 8'hE0}, {1'b1, 8'h00, 8'h02},
             {1'b0, 8'h9C, 8'h30}, {1'b0, 8'h9D, 8'h61}, {1'b0, 8'hA2, 8'hA4}, {1'b0, 8'hA3, 8'hA4} };

    repeat (3) @(posedge clock);
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_req_reg", 32'(req_reg), 32'd0);
    check("rst_req_data", 32'(req_data), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < N; i++) nk[i] = 0;
    do_run(nk, 1'b0, 0);
    nk[1] = 2;
    do_run(nk, 1'b0, 0);
    nk[1] = 0;
    nk[2] = 4;
    do_run(nk, 1'b0, 0);
    nk[2] = 0;
    do_run(nk, 1'b1, 0);
    do_run(nk, 1'b0, 50);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom % 20;
        nk[i] = (r < 13) ? 0 : (r < 16) ? 1 : (r < 18) ? $urandom_range(2, 3) : 4;
      end
      do_run(nk, 1'b0, 0);
    end

    for (int i = 0; i < N; i++) nk[i] = 0;
    plan_run(nk);
    ready_low = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    t = 0;
    while (!req_valid && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    check("issue_reached", 32'(req_valid), 32'd1);
    #2;
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_req_valid", 32'(req_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_req_fields", {16'd0, req_reg, req_data}, 32'd0);
    check("mid_rst_err_index", 32'(err_index), 32'd0);
    exp_q.delete();
    nack_q.delete();
    rsp_timer = 0;
    ready_low = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    do_run(nk, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
